// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: issues one data-memory access per
// load/store over a req/ack port, aligns load data and registers write-back inputs.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_is_b_type,
    input  logic        ex_is_jalr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_enable,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        is_b_type,
    output logic        is_jalr,
    output logic        misalign
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [1:0]  lat_off;
    logic [2:0]  lat_funct3;
    logic [4:0]  lat_dest;
    logic        lat_reg_write;
    logic        lat_b_type;
    logic        lat_jalr;

    logic        is_mem;
    logic        access_ok;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] load_value;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ex_ready = (state == IDLE);
    assign dmem_req = (state == WAIT);
    assign is_mem   = ex_mem_read | ex_mem_write;

    // Legality, byte enables and lane-replicated store data for the presented op.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        access_ok = 1'b0;
        req_be    = 4'b0000;
        req_wdata = ex_store_data;
        case (ex_funct3)
            3'b000, 3'b100: begin
                access_ok = (ex_funct3 == 3'b000) | ex_mem_read;
                req_be    = 4'b0001 << ex_alu_result[1:0];
                req_wdata = {4{ex_store_data[7:0]}};
            end
            3'b001, 3'b101: begin
                access_ok = ~ex_alu_result[0] & ((ex_funct3 == 3'b001) | ex_mem_read);
                req_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{ex_store_data[15:0]}};
            end
            3'b010: begin
                access_ok = (ex_alu_result[1:0] == 2'b00);
                req_be    = 4'b1111;
            end
            default: access_ok = 1'b0;
        endcase
    end

    // Load alignment and extension from the latched offset and size.
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (lat_off)
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            2'd3:    ld_byte = dmem_rdata[31:24];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_funct3)
            3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_value = {24'd0, ld_byte};
            3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_value = {16'd0, ld_half};
            default: load_value = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            lat_off       <= '0;
            lat_funct3    <= '0;
            lat_dest      <= '0;
            lat_reg_write <= 1'b0;
            lat_b_type    <= 1'b0;
            lat_jalr      <= 1'b0;
            wb_enable     <= 1'b0;
            wb_data       <= '0;
            wb_dest       <= '0;
            is_b_type     <= 1'b0;
            is_jalr       <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the defaults below form the bubble and later assignments override them.
            wb_enable <= 1'b0;
            wb_data   <= '0;
            wb_dest   <= '0;
            is_b_type <= 1'b0;
            is_jalr   <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid && !is_mem) begin
                        wb_enable <= ex_reg_write;
                        wb_data   <= ex_alu_result;
                        wb_dest   <= ex_dest;
                        is_b_type <= ex_is_b_type;
                        is_jalr   <= ex_is_jalr;
                    end else if (ex_valid && !access_ok) begin
                        misalign <= 1'b1;
                    end else if (ex_valid) begin
                        state         <= WAIT;
                        dmem_we       <= ex_mem_write;
                        dmem_addr     <= {ex_alu_result[31:2], 2'b00};
                        dmem_wdata    <= req_wdata;
                        dmem_be       <= req_be;
                        lat_off       <= ex_alu_result[1:0];
                        lat_funct3    <= ex_funct3;
                        lat_dest      <= ex_dest;
                        lat_reg_write <= ex_reg_write;
                        lat_b_type    <= ex_is_b_type;
                        lat_jalr      <= ex_is_jalr;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state     <= IDLE;
                        dmem_we   <= 1'b0;
                        wb_enable <= lat_reg_write & ~dmem_we;
                        wb_data   <= dmem_we ? 32'd0 : load_value;
                        wb_dest   <= lat_dest;
                        is_b_type <= lat_b_type;
                        is_jalr   <= lat_jalr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads and
// stores compared against an arithmetic reference model of the access rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        ex_is_b_type, ex_is_jalr;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        wb_enable;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        is_b_type, is_jalr, misalign;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_is_b_type(ex_is_b_type), .ex_is_jalr(ex_is_jalr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_enable(wb_enable), .wb_data(wb_data), .wb_dest(wb_dest),
        .is_b_type(is_b_type), .is_jalr(is_jalr), .misalign(misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: legality by size and alignment, loads by shift/mask arithmetic.
    function automatic bit model_legal(input bit ld, input logic [2:0] f3, input logic [31:0] addr);
        int size;
        bit known;
        known = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        size  = 1 << f3[1:0];
        return known && ((addr % size) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (rdata >> (8 * addr[1:0])) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rdata >> (16 * addr[1])) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd0) return 4'(1 << addr[1:0]);
        if (f3 == 3'd1) return 4'(3 << (2 * addr[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    task automatic alu_op(input logic [31:0] res, input logic [4:0] dest, input logic rw,
                          input logic b, input logic j);
        ex_valid = 1'b1; ex_alu_result = res; ex_dest = dest; ex_reg_write = rw;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_is_b_type = b; ex_is_jalr = j;
        tick();
        check("alu_wb_enable", 32'(wb_enable), 32'(rw));
        check("alu_wb_data", wb_data, res);
        check("alu_wb_dest", 32'(wb_dest), 32'(dest));
        check("alu_is_b_type", 32'(is_b_type), 32'(b));
        check("alu_is_jalr", 32'(is_jalr), 32'(j));
        check("alu_ready", 32'(ex_ready), 32'd1);
    endtask

    task automatic mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                          input logic [4:0] dest, input logic rw);
        bit legal;
        legal = model_legal(ld, f3, addr);
        ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = sdata; ex_dest = dest;
        ex_reg_write = rw; ex_mem_read = ld; ex_mem_write = !ld; ex_funct3 = f3;
        ex_is_b_type = 1'b0; ex_is_jalr = 1'b0;
        tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_store_data = $urandom; ex_alu_result = $urandom;
        if (!legal) begin
            check("bad_misalign", 32'(misalign), 32'd1);
            check("bad_no_req", 32'(dmem_req), 32'd0);
            check("bad_ready", 32'(ex_ready), 32'd1);
            check("bad_wb_enable", 32'(wb_enable), 32'd0);
            tick();
            check("bad_pulse_end", 32'(misalign), 32'd0);
            return;
        end
        check("mem_bubble", 32'(wb_enable), 32'd0);
        check("mem_no_misalign", 32'(misalign), 32'd0);
        for (int i = 1; i <= waits; i++) begin
            check("wait_req", 32'(dmem_req), 32'd1);
            check("wait_ready", 32'(ex_ready), 32'd0);
            check("wait_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("wait_we", 32'(dmem_we), 32'(!ld));
            if (!ld) begin
                check("wait_be", 32'(dmem_be), 32'(model_be(f3, addr)));
                check("wait_wdata", dmem_wdata, model_wdata(f3, sdata));
            end
            if (i == waits) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
        end
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        check("ret_ready", 32'(ex_ready), 32'd1);
        check("ret_req", 32'(dmem_req), 32'd0);
        check("ret_wb_enable", 32'(wb_enable), ld ? 32'(rw) : 32'd0);
        check("ret_wb_data", wb_data, ld ? model_load(f3, addr, rdata) : 32'd0);
        if (ld) check("ret_wb_dest", 32'(wb_dest), 32'(dest));
        tick();
        check("ret_one_cycle", 32'(wb_enable), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_dest = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
        ex_is_b_type = 1'b0; ex_is_jalr = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
        tick();
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb_enable", 32'(wb_enable), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        #2 rst = 1'b1;
        tick();
        check("rst_ready", 32'(ex_ready), 32'd1);

        // ALU op, then back-to-back random ALU ops retiring every cycle.
        alu_op(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            alu_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        ex_valid = 1'b0;
        tick();
        check("alu_drain", 32'(wb_enable), 32'd0);

        // Directed loads, store and misaligned word load.
        mem_op(1'b1, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 3, 5'd7, 1'b1);
        mem_op(1'b1, 3'd4, 32'h0000_0103, 32'd0, 32'h80FF_0000, 3, 5'd8, 1'b1);
        mem_op(1'b0, 3'd1, 32'h0000_0202, 32'hABCD_1234, 32'd0, 1, 5'd0, 1'b0);
        mem_op(1'b1, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 1, 5'd9, 1'b1);

        // Misaligned access followed immediately by an accepted ALU op.
        ex_valid = 1'b1; ex_alu_result = 32'h0000_0101; ex_mem_read = 1'b1; ex_funct3 = 3'd2;
        ex_reg_write = 1'b1; ex_dest = 5'd3;
        tick();
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_no_req", 32'(dmem_req), 32'd0);
        alu_op(32'h0000_0055, 5'd4, 1'b1, 1'b0, 1'b0);
        check("mis_pulse_end", 32'(misalign), 32'd0);

        // Branch pass-through with an ack in IDLE that must be ignored.
        dmem_ack = 1'b1;
        alu_op(32'h0000_0010, 5'd0, 1'b0, 1'b1, 1'b0);
        check("idle_ack_no_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        tick();

        // Randomized loads and stores, legal and illegal.
        for (int i = 0; i < 40; i++)
            mem_op(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(1, 4)), 5'($urandom), 1'($urandom));

        // Async reset in the middle of a WAIT abandons the access.
        ex_valid = 1'b1; ex_alu_result = 32'h0000_0040; ex_mem_read = 1'b1; ex_funct3 = 3'd2;
        tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        check("mid_wait_req", 32'(dmem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_req_drop", 32'(dmem_req), 32'd0);
        check("async_addr", dmem_addr, 32'd0);
        check("async_we", 32'(dmem_we), 32'd0);
        check("async_wdata", dmem_wdata, 32'd0);
        check("async_wb_enable", 32'(wb_enable), 32'd0);
        tick();
        #2 rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(ex_ready), 32'd1);
        check("post_rst_req", 32'(dmem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
